button_pulse_gen: RTL

Debounces and edge-detects raw push-button inputs. Emits the single-cycle rising-edge pulses (`*_re` strobes such as next-segment and change-mode) that the segment display drivers consume. Sits between the board pins and the display FSMs. Optionally auto-repeats the pulse while a button is held.

---
 rtl/button_pulse_gen_pkg.sv | 22 ++
 rtl/button_pulse_gen_debouncer.sv | 139 +++++++++++++
 rtl/button_pulse_gen.sv | 37 +++
 3 files changed

// File: rtl/button_pulse_gen_pkg.sv
// Shared definitions for the push-button pulse generator: the per-channel
// FSM state encoding and small elaboration-time helpers for counter sizing.
package button_pulse_gen_pkg;

  // Per-channel button FSM states
  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    PRESSED   = 2'd1,
    REPEATING = 2'd2
  } btn_state_t;

  // Larger of two integers, used to size the shared repeat counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to count 0..n-1, never less than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_pulse_gen_debouncer.sv
// One push-button channel: two-flop synchronizer with polarity
// normalisation, a stable-level debounce counter, and a small FSM that
// emits a one-cycle strobe on each accepted press and, optionally, on a
// fixed auto-repeat schedule while the button stays held.
module button_debouncer
  import button_pulse_gen_pkg::*;
#(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic sync_reset,
  input  logic btn_raw,
  output logic pulse_re,
  output logic level
);

  localparam int DB_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int REP_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  // Raw pin value that means "not pressed"
  localparam logic RELEASED_RAW = ACTIVE_LOW;

  logic [1:0]       sync_q;
  logic             btn_sync;
  logic [DB_W-1:0]  db_cnt;
  logic             level_q;
  logic             db_done;
  logic             accept_press;
  logic             accept_release;

  btn_state_t       state_q;
  btn_state_t       state_d;
  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_cnt_d;
  logic             pulse_d;

  // Two-stage synchronizer; reset loads the released level so a button
  // held through reset is seen as a fresh press afterwards
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      sync_q <= {2{RELEASED_RAW}};
    end else begin
      sync_q <= {sync_q[0], btn_raw};
    end
  end

  assign btn_sync = sync_q[1] ^ ACTIVE_LOW;

  // The debounced level only follows btn_sync once it has disagreed for
  // DEBOUNCE_CYCLES consecutive cycles
  assign db_done        = (btn_sync != level_q) && (db_cnt == DB_LAST);
  assign accept_press   = db_done && !level_q;
  assign accept_release = db_done && level_q;

  // Debounce counter and accepted level
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      db_cnt  <= '0;
      level_q <= 1'b0;
    end else if (btn_sync == level_q) begin
      db_cnt  <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt  <= '0;
      level_q <= ~level_q;
    end else begin
      db_cnt  <= db_cnt + 1'b1;
    end
  end

  // Next state, repeat counter and strobe; a release always wins over a
  // repeat that would fall due in the same cycle
  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt;
    pulse_d   = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (accept_press) begin
          state_d   = PRESSED;
          pulse_d   = 1'b1;
          rep_cnt_d = '0;
        end
      end
      PRESSED: begin
        if (accept_release) begin
          state_d   = RELEASED;
          rep_cnt_d = '0;
        end else if (REPEAT_EN) begin
          if (rep_cnt == DELAY_LAST) begin
            state_d   = REPEATING;
            pulse_d   = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt + 1'b1;
          end
        end
      end
      REPEATING: begin
        if (accept_release) begin
          state_d   = RELEASED;
          rep_cnt_d = '0;
        end else if (rep_cnt == PERIOD_LAST) begin
          pulse_d   = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt + 1'b1;
        end
      end
      default: begin
        state_d   = RELEASED;
        rep_cnt_d = '0;
      end
    endcase
  end

  // FSM state, repeat counter and registered strobe
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q  <= RELEASED;
      rep_cnt  <= '0;
      pulse_re <= 1'b0;
    end else begin
      state_q  <= state_d;
      rep_cnt  <= rep_cnt_d;
      pulse_re <= pulse_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/button_pulse_gen.sv
// Multi-channel push-button front end: one independent debouncer per
// button, producing press/repeat strobes and debounced pressed levels.
module button_pulse_gen
  import button_pulse_gen_pkg::*;
#(
  parameter int                  CHANNELS        = 2,
  parameter bit                  ACTIVE_LOW      = 1'b1,
  parameter int                  DEBOUNCE_CYCLES = 500000,
  parameter logic [CHANNELS-1:0] REPEAT_EN       = '0,
  parameter int                  REPEAT_DELAY    = 25000000,
  parameter int                  REPEAT_PERIOD   = 5000000
) (
  input  logic                clk,
  input  logic                sync_reset,
  input  logic [CHANNELS-1:0] btn_raw,
  output logic [CHANNELS-1:0] pulse_re,
  output logic [CHANNELS-1:0] level
);

  // Channels share nothing, so each bit gets its own debouncer
  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    button_debouncer #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_EN[ch])
    ) u_debouncer (
      .clk        (clk),
      .sync_reset (sync_reset),
      .btn_raw    (btn_raw[ch]),
      .pulse_re   (pulse_re[ch]),
      .level      (level[ch])
    );
  end

endmodule
